muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV32M multiply/divide unit sitting beside the single-cycle ALU in the EX stage. It executes all eight M-extension operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU), selected by funct3 when funct7[0] is set. It uses a start/busy/done handshake so the hazard unit can stall the pipeline while an operation is in flight. Width is parametrised so the same block serves a future RV64 build.

## Interface
- XLEN, 32, operand and result width (≥ 8, even)
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  request; sampled only when busy=0
- flush  in  1  kill in-flight operation (pipeline flush)
- funct3  in  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  in  XLEN  rs1 / dividend
- op_b  in  XLEN  rs2 / divisor
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse; result valid
- result  out  XLEN  result; held until the next done
- illegal  out  1  accompanies done when the op is not supported in this build

## Operation
- FSM states: IDLE, MUL, DIV, DONE. Reset puts the FSM in IDLE with busy=0, done=0, illegal=0, result=0.
- The block latches funct3, op_a, and op_b on any edge where start=1 and busy=0 (states IDLE or DONE).
- Multiply path (funct3[2]=0):
  - IDLE→MUL→DONE.
  - A 2·XLEN-bit product is formed with operand sign handling per op: MULHSU treats op_a as signed and op_b as unsigned.
  - MUL returns the low XLEN bits. MULH/MULHSU/MULHU return the high XLEN bits.
- Divide path (funct3[2]=1):
  - IDLE→DIV, then XLEN restoring iterations on magnitudes, one per cycle, then DONE.
  - Signed ops: quotient is negated when the operand signs differ. Remainder takes the sign of the dividend.
- Divide special cases are detected at latch time and bypass the iterations (DIV→DONE after 1 cycle):
  - Divisor = 0: DIV/DIVU quotient = all ones; REM/REMU = op_a.
  - Signed overflow (op_a = 1 followed by XLEN-1 zeros, op_b = all ones): DIV = op_a; REM = 0.
- DONE: done=1 for exactly one cycle, then →IDLE, unless a new start is accepted on that edge, in which case →MUL/DIV.
- flush=1 in any state: next state is IDLE, done is not raised, result keeps its old value. flush overrides a simultaneous start.
- rst mid-operation: state, busy, done, illegal, and result return to their reset values on that edge.

## Timing
- Cycle 0 is the edge that accepts start.
- busy=1 from cycle 0 through the edge before DONE. busy=0 in IDLE and DONE.
- Multiply: done high in cycle 2 (latency 2).
- Divide (normal): done high in cycle XLEN+2, which is 34 for XLEN=32.
- Divide (special case): done high in cycle 2.
- result updates on the same edge that raises done.
- A start arriving while busy=1 is ignored: it is not queued and not latched.
- Back-to-back issue: a start accepted during DONE begins the new operation with no idle cycle.

## Configuration
- MULDIV_DIV_EN defined: full behaviour as above.
- MULDIV_DIV_EN undefined:
  - Divider datapath is omitted.
  - Any divide funct3 goes IDLE→DONE in 1 cycle, with done high in cycle 1, result=0, illegal=1.
  - Multiply ops are unchanged and always have illegal=0.

## Test plan
- MUL with op_a=7, op_b=0xFFFFFFFD (−3) → done in cycle 2, result=0xFFFFFFEB. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- DIV −7/2 → 0xFFFFFFFD (−3). REM −7/2 → 0xFFFFFFFF (−1). DIVU 100/7 → 14. Each has done in cycle 34 and busy=1 for cycles 0–33.
- Divisor 0: DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5. Overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0. All complete with done in cycle 2.
- Start DIVU, then a second start at cycle 5 is ignored. flush at cycle 10 → no done, busy=0 in cycle 11, result unchanged. A new MUL 3×4 then yields 12.
- rst asserted at cycle 15 of a divide → outputs all 0 next cycle. A start during DONE runs MUL back-to-back with done pulses exactly 2 cycles apart.
- Built without MULDIV_DIV_EN: DIV 10/2 → done in cycle 1, result=0, illegal=1. MUL 6×7 → 42, illegal=0.

Source files
------------

// File: rtl/muldiv_if.sv
// Start/busy/done handshake bundle between the EX stage and the RV32M multiply/divide unit.
interface muldiv_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            flush;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic            illegal;

  modport master (
    output start, flush, funct3, op_a, op_b,
    input  busy, done, result, illegal
  );

  modport slave (
    input  start, flush, funct3, op_a, op_b,
    output busy, done, result, illegal
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
// Define MULDIV_DIV_EN to build the restoring divider; otherwise divide ops complete flagged illegal.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic    clk,
  input  logic    rst,
  muldiv_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]               state;
  logic                     busy;
  logic                     accept;
  logic                     illegal_r;
  logic [XLEN-1:0]          result_r;
  logic [1:0]               f3_p0;
  logic [XLEN-1:0]          a_p0;
  logic [XLEN-1:0]          b_p0;
  logic signed [2*XLEN-1:0] mul_a;
  logic signed [2*XLEN-1:0] mul_b;
  logic signed [2*XLEN-1:0] prod;
  logic [XLEN-1:0]          mul_res;

  assign busy        = (state == S_MUL) || (state == S_DIV);
  assign accept      = bus.start && !busy && !bus.flush;
  assign bus.busy    = busy;
  assign bus.done    = (state == S_DONE);
  assign bus.illegal = illegal_r;
  assign bus.result  = result_r;

  // Stage p0: operands captured on the accepting edge
  always_ff @(posedge clk) begin
    if (accept) begin
      f3_p0 <= bus.funct3[1:0];
      a_p0  <= bus.op_a;
      b_p0  <= bus.op_b;
    end
  end

  // op_a is signed except for MULHU; op_b is signed only for MUL/MULH
  always_comb begin
    mul_a   = {{XLEN{a_p0[XLEN-1] & (f3_p0 != 2'b11)}}, a_p0};
    mul_b   = {{XLEN{b_p0[XLEN-1] & !f3_p0[1]}}, b_p0};
    prod    = mul_a * mul_b;
    mul_res = (f3_p0 == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

`ifdef MULDIV_DIV_EN
  localparam int CNT_W = $clog2(XLEN + 1);

  function automatic logic [XLEN-1:0] apply_sign(input logic [XLEN-1:0] mag, input logic neg);
    return neg ? -mag : mag;
  endfunction

  logic             div_sgn;
  logic             a_neg;
  logic             b_neg;
  logic             b_zero;
  logic             ovf;
  logic             spec;
  logic [XLEN-1:0]  spec_res;
  logic [XLEN-1:0]  rem_p1;
  logic [XLEN-1:0]  quo_p1;
  logic [XLEN-1:0]  dvs_p1;
  logic [CNT_W-1:0] cnt_p1;
  logic             spec_p1;
  logic             neg_q_p1;
  logic             neg_r_p1;
  logic [XLEN:0]    trial;
  logic             div_last;
  logic [XLEN-1:0]  div_res;

  // Special cases are resolved from the raw operands so they skip the iteration loop
  always_comb begin
    div_sgn = !bus.funct3[0];
    a_neg   = div_sgn & bus.op_a[XLEN-1];
    b_neg   = div_sgn & bus.op_b[XLEN-1];
    b_zero  = (bus.op_b == '0);
    ovf     = div_sgn && (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) && (&bus.op_b);
    spec    = b_zero | ovf;
    if (bus.funct3[1]) spec_res = b_zero ? bus.op_a : '0;
    else               spec_res = b_zero ? '1 : bus.op_a;
  end

  assign trial    = {rem_p1, quo_p1[XLEN-1]} - {1'b0, dvs_p1};
  assign div_last = spec_p1 || (cnt_p1 == CNT_W'(XLEN));

  always_comb begin
    if (spec_p1)       div_res = quo_p1;
    else if (f3_p0[1]) div_res = apply_sign(rem_p1, neg_r_p1);
    else               div_res = apply_sign(quo_p1, neg_q_p1);
  end

  // Stage p1: restoring divide on magnitudes, dividend shifts out of quo_p1 as quotient shifts in
  always_ff @(posedge clk) begin
    if (accept) begin
      rem_p1   <= '0;
      quo_p1   <= spec ? spec_res : apply_sign(bus.op_a, a_neg);
      dvs_p1   <= apply_sign(bus.op_b, b_neg);
      cnt_p1   <= '0;
      spec_p1  <= spec;
      neg_q_p1 <= a_neg ^ b_neg;
      neg_r_p1 <= a_neg;
    end else if (state == S_DIV && !div_last) begin
      rem_p1 <= trial[XLEN] ? {rem_p1[XLEN-2:0], quo_p1[XLEN-1]} : trial[XLEN-1:0];
      quo_p1 <= {quo_p1[XLEN-2:0], !trial[XLEN]};
      cnt_p1 <= cnt_p1 + CNT_W'(1);
    end
  end
`endif

  // Control: flush wins over everything except reset and leaves result untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      illegal_r <= 1'b0;
      result_r  <= '0;
    end else begin
      illegal_r <= 1'b0;
      if (bus.flush) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_MUL: begin
            state    <= S_DONE;
            result_r <= mul_res;
          end
`ifdef MULDIV_DIV_EN
          S_DIV: begin
            if (div_last) begin
              state    <= S_DONE;
              result_r <= div_res;
            end
          end
`endif
          default: begin
            if (!accept) begin
              state <= S_IDLE;
            end else if (!bus.funct3[2]) begin
              state <= S_MUL;
            end else begin
`ifdef MULDIV_DIV_EN
              state <= S_DIV;
`else
              state     <= S_DONE;
              illegal_r <= 1'b1;
              result_r  <= '0;
`endif
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
  localparam int XLEN = 32;
`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [31:0] last_res = '0;

  muldiv_if #(.XLEN(XLEN)) bus ();
  muldiv_unit #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    case (f)
      3'b000: return a * b;
      3'b001: begin p = longint'(int'(a)) * longint'(int'(b)); return p[63:32]; end
      3'b010: begin p = longint'(int'(a)) * longint'({32'b0, a == a ? b : b}); return p[63:32]; end
      3'b011: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      default: begin
        if (!DIV_EN) return '0;
        if (b == 0) return f[1] ? a : 32'hFFFF_FFFF;
        if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f[1] ? 32'h0 : a;
        case (f[1:0])
          2'b00:   return int'(a) / int'(b);
          2'b01:   return a / b;
          2'b10:   return int'(a) % int'(b);
          default: return a % b;
        endcase
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[2]) return 2;
    if (!DIV_EN) return 1;
    if (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 2;
    return XLEN + 2;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 15);
      default: return $urandom();
    endcase
  endfunction

  // Drives start at a negedge so it is taken on the next rising edge (cycle 0); returns at cycle 1
  task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = f; bus.op_a = a; bus.op_b = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int from, output int lat, output int busy_n);
    lat = from; busy_n = 0;
    while (!bus.done && lat < 60) begin
      if (bus.busy) busy_n++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int lat, bn, exp_lat;
    exp_lat = ref_latency(f, a, b);
    start_op(f, a, b);
    wait_done(1, lat, bn);
    chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".busy_cycles"}, 32'(bn), 32'(exp_lat - 1));
    chk({tag, ".result"}, bus.result, ref_result(f, a, b));
    chk({tag, ".illegal"}, 32'(bus.illegal), 32'(f[2] && !DIV_EN));
    chk({tag, ".busy_in_done"}, 32'(bus.busy), 32'h0);
    last_res = ref_result(f, a, b);
    @(negedge clk);
    chk({tag, ".done_pulse"}, 32'(bus.done), 32'h0);
  endtask

  initial begin
    int lat, bn, ev, seen;
    logic [2:0]  f1;
    logic [31:0] a1, b1;
    bus.start = 1'b0; bus.flush = 1'b0; bus.funct3 = '0; bus.op_a = '0; bus.op_b = '0;

    repeat (3) @(negedge clk);
    chk("rst.busy", 32'(bus.busy), 32'h0);
    chk("rst.done", 32'(bus.done), 32'h0);
    chk("rst.illegal", 32'(bus.illegal), 32'h0);
    chk("rst.result", bus.result, 32'h0);
    rst = 1'b0;

    run_op("mul_7_m3", 3'b000, 32'd7, 32'hFFFF_FFFD);
    run_op("mulhu_max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mulh_neg", 3'b001, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2);
    run_op("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2);
    run_op("divu_100_7", 3'b101, 32'd100, 32'd7);
    run_op("div_5_0", 3'b100, 32'd5, 32'd0);
    run_op("remu_5_0", 3'b111, 32'd5, 32'd0);
    run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("div_10_2", 3'b100, 32'd10, 32'd2);
    run_op("mul_6_7", 3'b000, 32'd6, 32'd7);

    for (int i = 0; i < 40; i++)
      run_op($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)), pick(), pick());

    // A start while busy is neither latched nor queued
    f1 = DIV_EN ? 3'b101 : 3'b000; a1 = 32'd1000; b1 = 32'd7;
    ev = DIV_EN ? 5 : 1;
    start_op(f1, a1, b1);
    repeat (ev - 1) @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'b000; bus.op_a = 32'd3; bus.op_b = 32'd4;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(ev + 1, lat, bn);
    chk("ignore.lat", 32'(lat), 32'(ref_latency(f1, a1, b1)));
    chk("ignore.result", bus.result, ref_result(f1, a1, b1));
    last_res = ref_result(f1, a1, b1);
    @(negedge clk);
    chk("ignore.no_queue_busy", 32'(bus.busy), 32'h0);
    chk("ignore.no_queue_done", 32'(bus.done), 32'h0);

    // Flush kills the operation without a done and keeps the old result
    ev = DIV_EN ? 10 : 1;
    start_op(f1, 32'd555, b1);
    repeat (ev - 1) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush.busy", 32'(bus.busy), 32'h0);
    chk("flush.done", 32'(bus.done), 32'h0);
    chk("flush.result", bus.result, last_res);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    chk("flush.no_late_done", 32'(seen), 32'h0);
    run_op("mul_3_4", 3'b000, 32'd3, 32'd4);

    // Reset in flight clears every output on the following cycle
    ev = DIV_EN ? 15 : 1;
    start_op(DIV_EN ? 3'b100 : 3'b000, 32'd12345, 32'd17);
    repeat (ev - 1) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst.busy", 32'(bus.busy), 32'h0);
    chk("midrst.done", 32'(bus.done), 32'h0);
    chk("midrst.illegal", 32'(bus.illegal), 32'h0);
    chk("midrst.result", bus.result, 32'h0);
    rst = 1'b0;

    // Start taken in DONE: next op issues with no idle cycle between them
    start_op(3'b000, 32'd6, 32'd7);
    wait_done(1, lat, bn);
    chk("b2b.first_lat", 32'(lat), 32'd2);
    chk("b2b.first_result", bus.result, 32'd42);
    bus.start = 1'b1; bus.funct3 = 3'b000; bus.op_a = 32'd9; bus.op_b = 32'd9;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(1, lat, bn);
    chk("b2b.spacing", 32'(lat), 32'd2);
    chk("b2b.second_result", bus.result, 32'd81);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
